uart_receiver: RTL and testbench

- UART 8N1 receive path; the counterpart of the existing transmitter on the same serial link.
- Oversamples Serial_in at 16x the baud rate using a one-cycle sample_tick enable supplied by a tick_generator instance.
- Qualifies the start bit, samples at mid-bit, checks the stop bit and holds the byte in a data register for the host.
- Host handshake: data_valid / read_ack; sticky overrun and framing flags.

---
 rtl/uart_receiver.sv | 169 ++++++++++++++++
 tb/tb_uart_receiver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver
//   8N1 UART receive path. The serial line is oversampled by `oversample` using
//   a one-Clock-wide sample_tick enable. A start bit is qualified by `half_bit`
//   consecutive low samples. Data bits are sampled near mid-bit, LSB first. The
//   stop bit is checked, and a good byte is held in Data_out until the host
//   acknowledges it.
//
// Ports
//   Clock        system clock, all state on posedge
//   reset_       asynchronous, active-high reset
//   sample_tick  one-cycle enable at oversample x baud
//   Serial_in    asynchronous serial line, idle high
//   read_ack     host pulse: byte consumed, clears data_valid and both flags
//   Data_out     last good received byte
//   data_valid   Data_out holds an unread byte
//   overrun_err  sticky: a good byte completed while data_valid was set
//   framing_err  sticky: stop bit sampled low
module uart_receiver #(
  parameter int word_size  = 8,
  parameter int oversample = 16,
  parameter int half_bit   = 8,
  parameter int cnt_width  = 4
) (
  input  logic                 Clock,
  input  logic                 reset_,
  input  logic                 sample_tick,
  input  logic                 Serial_in,
  input  logic                 read_ack,
  output logic [word_size-1:0] Data_out,
  output logic                 data_valid,
  output logic                 overrun_err,
  output logic                 framing_err
);

  localparam int bit_width = $clog2(word_size) + 1;

  // One-hot state encoding
  localparam logic [4:0] IDLE  = 5'b00001;
  localparam logic [4:0] START = 5'b00010;
  localparam logic [4:0] DATA  = 5'b00100;
  localparam logic [4:0] STOP  = 5'b01000;
  localparam logic [4:0] BREAK = 5'b10000;

  logic                 rx_meta;
  logic                 rx;
  logic [4:0]           state;
  logic [cnt_width-1:0] sample_cnt;
  logic [bit_width-1:0] bit_cnt;
  logic [word_size-1:0] shift_reg;

  logic mid_bit;
  logic good_stop;
  logic bad_stop;
  logic load;
  logic overrun;

  // Two-flop synchronizer; both flops reset to the idle (high) line level so
  // reset release never looks like a start bit.
  always_ff @(posedge Clock or posedge reset_) begin
    if (reset_) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= Serial_in;
      rx      <= rx_meta;
    end
  end

  always_comb begin
    mid_bit   = (sample_cnt == cnt_width'(oversample - 1));
    good_stop = (state == STOP) && sample_tick && mid_bit && rx;
    bad_stop  = (state == STOP) && sample_tick && mid_bit && !rx;
    // An ack in the load cycle frees the register, so the new byte is taken
    // instead of being reported as an overrun.
    load      = good_stop && (!data_valid || read_ack);
    overrun   = good_stop && data_valid && !read_ack;
  end

  // Receive state machine
  always_ff @(posedge Clock or posedge reset_) begin
    if (reset_) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else if (sample_tick) begin
      case (state)
        IDLE: begin
          if (!rx) begin
            state      <= START;
            sample_cnt <= cnt_width'(1);
          end
        end
        START: begin
          if (rx) begin
            state      <= IDLE;
            sample_cnt <= '0;
          end else if (sample_cnt == cnt_width'(half_bit - 1)) begin
            state      <= DATA;
            sample_cnt <= '0;
            bit_cnt    <= '0;
          end else begin
            sample_cnt <= sample_cnt + cnt_width'(1);
          end
        end
        DATA: begin
          if (mid_bit) begin
            sample_cnt <= '0;
            shift_reg  <= {rx, shift_reg[word_size-1:1]};
            bit_cnt    <= bit_cnt + bit_width'(1);
            if (bit_cnt == bit_width'(word_size - 1))
              state <= STOP;
          end else begin
            sample_cnt <= sample_cnt + cnt_width'(1);
          end
        end
        STOP: begin
          if (mid_bit) begin
            sample_cnt <= '0;
            state      <= rx ? IDLE : BREAK;
          end else begin
            sample_cnt <= sample_cnt + cnt_width'(1);
          end
        end
        BREAK: begin
          // A line held low must return high before a new start is accepted.
          if (rx) begin
            state      <= IDLE;
            sample_cnt <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          sample_cnt <= '0;
        end
      endcase
    end
  end

  // Host-side output register and sticky flags
  always_ff @(posedge Clock or posedge reset_) begin
    if (reset_) begin
      Data_out    <= '0;
      data_valid  <= 1'b0;
      overrun_err <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (load) begin
        Data_out   <= shift_reg;
        data_valid <= 1'b1;
      end else if (read_ack) begin
        data_valid <= 1'b0;
      end

      if (overrun)
        overrun_err <= 1'b1;
      else if (read_ack)
        overrun_err <= 1'b0;

      // Setting takes priority over an ack arriving in the same cycle.
      if (bad_stop)
        framing_err <= 1'b1;
      else if (read_ack)
        framing_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// tb_uart_receiver
//   Self-checking bench for uart_receiver: reset state, a table of scripted
//   frames, hand-written corner-case sequences (exact load latency, ack on the
//   load cycle, reset mid-frame, +/-3% baud skew) and randomized frames checked
//   against a frame-level reference model.
module tb_uart_receiver;

  localparam int TICK_DIV = 4;              // Clocks per sample_tick
  localparam int BIT_CLKS = 16 * TICK_DIV;  // Clocks per nominal bit

  logic       Clock = 1'b0;
  logic       reset_ = 1'b1;
  logic       sample_tick = 1'b0;
  logic       Serial_in = 1'b1;
  logic       read_ack = 1'b0;
  logic [7:0] Data_out;
  logic       data_valid;
  logic       overrun_err;
  logic       framing_err;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;

  // Frame-level reference model of the host-visible outputs
  logic [7:0] m_dout = 8'h00;
  logic       m_dv = 1'b0;
  logic       m_ov = 1'b0;
  logic       m_fe = 1'b0;

  uart_receiver #(
    .word_size (8),
    .oversample(16),
    .half_bit  (8),
    .cnt_width (4)
  ) dut (
    .Clock      (Clock),
    .reset_     (reset_),
    .sample_tick(sample_tick),
    .Serial_in  (Serial_in),
    .read_ack   (read_ack),
    .Data_out   (Data_out),
    .data_valid (data_valid),
    .overrun_err(overrun_err),
    .framing_err(framing_err)
  );

  always #5 Clock = ~Clock;

  // Tick generator: one full Clock period high every TICK_DIV clocks
  always @(negedge Clock) begin
    sample_tick <= (tick_cnt == 0);
    tick_cnt    <= (tick_cnt + 1) % TICK_DIV;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         extra_low;  // extra clocks the line stays low after a bad stop bit
    logic       glitch;     // short low pulse before the frame
    logic       ack;        // acknowledge after checking
    logic [7:0] e_dout;
    logic       e_dv;
    logic       e_ov;
    logic       e_fe;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " Data_out"},    32'(Data_out),    32'(m_dout));
    check({tag, " data_valid"},  32'(data_valid),  32'(m_dv));
    check({tag, " overrun_err"}, 32'(overrun_err), 32'(m_ov));
    check({tag, " framing_err"}, 32'(framing_err), 32'(m_fe));
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (stop) begin
      if (m_dv) m_ov = 1'b1;
      else begin
        m_dout = d;
        m_dv   = 1'b1;
      end
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic model_ack();
    m_dv = 1'b0;
    m_ov = 1'b0;
    m_fe = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge Clock);
    read_ack = 1'b1;
    @(negedge Clock);
    read_ack = 1'b0;
  endtask

  // Returns on the negedge right after a posedge that carried a sample_tick
  task automatic align();
    do @(posedge Clock); while (sample_tick !== 1'b1);
    @(negedge Clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk,
                            input int extra_low, input int gap);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Serial_in = bits[i];
      repeat (bclk) @(negedge Clock);
    end
    if (!stop) repeat (extra_low) @(negedge Clock);
    Serial_in = 1'b1;
    repeat (gap) @(negedge Clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0] = '{data: 8'h3C, stop: 1'b1, extra_low: 0,   glitch: 1'b1, ack: 1'b1,
                e_dout: 8'h3C, e_dv: 1'b1, e_ov: 1'b0, e_fe: 1'b0};
    vecs[1] = '{data: 8'h55, stop: 1'b0, extra_low: 160, glitch: 1'b0, ack: 1'b0,
                e_dout: 8'h3C, e_dv: 1'b0, e_ov: 1'b0, e_fe: 1'b1};
    vecs[2] = '{data: 8'h0F, stop: 1'b1, extra_low: 0,   glitch: 1'b0, ack: 1'b1,
                e_dout: 8'h0F, e_dv: 1'b1, e_ov: 1'b0, e_fe: 1'b1};
    vecs[3] = '{data: 8'h11, stop: 1'b1, extra_low: 0,   glitch: 1'b0, ack: 1'b0,
                e_dout: 8'h11, e_dv: 1'b1, e_ov: 1'b0, e_fe: 1'b0};
    vecs[4] = '{data: 8'h22, stop: 1'b1, extra_low: 0,   glitch: 1'b0, ack: 1'b1,
                e_dout: 8'h11, e_dv: 1'b1, e_ov: 1'b1, e_fe: 1'b0};

    // Reset state
    repeat (3) @(negedge Clock);
    check_model("reset");
    reset_ = 1'b0;
    repeat (4) @(negedge Clock);

    // Nominal 0xA5 with exact load latency: start edge driven after a tick
    // posedge P0, detection at P4, mid-stop load 151 ticks later at P608.
    align();
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, BIT_CLKS, 0, BIT_CLKS);
      begin
        for (int n = 1; n <= 700; n++) begin
          @(posedge Clock);
          #1;
          lat = n;
          if (data_valid) break;
        end
      end
    join
    check("nominal latency", 32'(lat), 32'd608);
    model_frame(8'hA5, 1'b1);
    check_model("nominal A5");
    ack_pulse();
    model_ack();
    check("nominal ack data_valid", 32'(data_valid), 32'd0);

    // Scripted frames
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].glitch) begin
        align();
        Serial_in = 1'b0;
        repeat (5 * TICK_DIV) @(negedge Clock);
        Serial_in = 1'b1;
        repeat (BIT_CLKS) @(negedge Clock);
        check("glitch data_valid", 32'(data_valid), 32'd0);
        check("glitch flags", 32'({overrun_err, framing_err}), 32'd0);
      end
      align();
      send_frame(vecs[i].data, vecs[i].stop, BIT_CLKS, vecs[i].extra_low, BIT_CLKS);
      model_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d Data_out", i),    32'(Data_out),    32'(vecs[i].e_dout));
      check($sformatf("vec%0d data_valid", i),  32'(data_valid),  32'(vecs[i].e_dv));
      check($sformatf("vec%0d overrun_err", i), 32'(overrun_err), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d framing_err", i), 32'(framing_err), 32'(vecs[i].e_fe));
      if (vecs[i].ack) begin
        ack_pulse();
        model_ack();
        check($sformatf("vec%0d ack outputs", i),
              32'({data_valid, overrun_err, framing_err}), 32'd0);
        check($sformatf("vec%0d ack Data_out", i), 32'(Data_out), 32'(vecs[i].e_dout));
      end
    end

    // Ack on the exact load cycle of the second byte
    align();
    send_frame(8'h11, 1'b1, BIT_CLKS, 0, BIT_CLKS);
    model_frame(8'h11, 1'b1);
    check_model("simul first");
    align();
    fork
      send_frame(8'h22, 1'b1, BIT_CLKS, 0, BIT_CLKS);
      begin
        repeat (607) @(posedge Clock);
        @(negedge Clock);
        read_ack = 1'b1;
        @(posedge Clock);
        #1;
        check("simul Data_out", 32'(Data_out), 32'h22);
        check("simul data_valid", 32'(data_valid), 32'd1);
        check("simul overrun_err", 32'(overrun_err), 32'd0);
        @(negedge Clock);
        read_ack = 1'b0;
      end
    join
    m_dout = 8'h22;
    m_dv   = 1'b1;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
    check_model("simul after");

    // Reset in the middle of the fifth data bit of 0xFF
    align();
    fork
      send_frame(8'hFF, 1'b1, BIT_CLKS, 0, BIT_CLKS);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge Clock);
        #2;
        reset_ = 1'b1;
        #1;
        check("midreset outputs",
              32'({Data_out, data_valid, overrun_err, framing_err}), 32'd0);
        repeat (3) @(negedge Clock);
        reset_ = 1'b0;
      end
    join
    m_dout = 8'h00;
    model_ack();
    check_model("after midreset frame");
    align();
    send_frame(8'h81, 1'b1, BIT_CLKS, 0, BIT_CLKS);
    model_frame(8'h81, 1'b1);
    check_model("post-reset 81");
    ack_pulse();
    model_ack();

    // +/-3% baud skew
    for (int s = 0; s < 2; s++) begin
      int bclk;
      bclk = (s == 0) ? 62 : 66;
      align();
      send_frame(8'hA5, 1'b1, bclk, 0, BIT_CLKS);
      model_frame(8'hA5, 1'b1);
      check_model($sformatf("skew %0d", bclk));
      ack_pulse();
      model_ack();
    end

    // Randomized frames against the reference model
    for (int r = 0; r < 24; r++) begin
      logic [7:0] d;
      logic       stop;
      int         bclk;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      bclk = $urandom_range(62, 66);
      align();
      send_frame(d, stop, bclk, $urandom_range(0, 100), $urandom_range(64, 200));
      model_frame(d, stop);
      check_model($sformatf("rand%0d", r));
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        model_ack();
        check_model($sformatf("rand%0d ack", r));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
